// File: rtl/oam_dma.sv
// Block-copy engine: streams LEN words from a 1-cycle-latency source bus into a sprite RAM write port.
// Optional per-slot pacing is enabled by defining OAM_DMA_PACE_EN.
module oam_dma #(
   parameter int unsigned aw   = 8,
   parameter int unsigned dw   = 8,
   parameter int unsigned saw  = 16,
   parameter int unsigned LEN  = 160,
   parameter int unsigned PACE = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [saw-1:0] src_base_i,
   output logic           busy_o,
   output logic           done_o,
   input  logic           src_gnt_i,
   output logic           src_ce_o,
   output logic [saw-1:0] src_addr_o,
   input  logic [dw-1:0]  src_din_i,
   output logic           dst_ce_o,
   output logic           dst_we_o,
   output logic [aw-1:0]  dst_addr_o,
   output logic [dw-1:0]  dst_din_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   localparam logic [aw:0] LAST = (aw+1)'(LEN-1);

   state_t         state_q, state_d;
   logic [aw:0]    idx_q, idx_d;
   logic [saw-1:0] base_q, base_d;
   logic [saw-1:0] addr_q, addr_d;
   logic           wr_q, wr_d;
   logic [aw-1:0]  waddr_q, waddr_d;
   logic           slot_ok;
   logic           rd_fire;
   logic           busy, done;
   logic [saw-1:0] rd_addr;

`ifdef OAM_DMA_PACE_EN
   localparam int unsigned PW = (PACE > 1) ? $clog2(PACE) : 1;
   localparam logic [PW-1:0] SLOT_LAST = PW'(PACE-1);

   logic [PW-1:0] slot_q, slot_d;

   always_comb begin
      slot_d = slot_q + 1'b1;
      if (start_i || slot_q == SLOT_LAST) slot_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) slot_q <= '0;
      else       slot_q <= slot_d;
   end

   // A stalled slot is simply lost; the next opportunity is PACE clocks later.
   assign slot_ok = (slot_q == SLOT_LAST);
`else
   // Unpaced: every granted clock is a slot (any legal PACE is >= 1).
   assign slot_ok = (PACE != 0);
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      addr_d  = addr_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      busy    = 1'b0;
      done    = 1'b0;
      rd_fire = 1'b0;
      rd_addr = base_q + saw'(idx_q);

      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            busy = 1'b1;
            if (src_gnt_i && slot_ok) begin
               rd_fire = 1'b1;
               wr_d    = 1'b1;
               waddr_d = idx_q[aw-1:0];
               addr_d  = rd_addr;
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            done    = !start_i;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Restart wins over everything; a read issued this cycle still lands next cycle.
      if (start_i) begin
         state_d = S_RUN;
         idx_d   = '0;
         base_d  = src_base_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
      end
   end

   assign busy_o     = busy;
   assign done_o     = done;
   assign src_ce_o   = rd_fire;
   assign src_addr_o = rd_fire ? rd_addr : addr_q;
   assign dst_ce_o   = wr_q;
   assign dst_we_o   = wr_q;
   assign dst_addr_o = waddr_q;
   assign dst_din_o  = wr_q ? src_din_i : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: per-cycle comparison against an integer-level transfer model,
// plus hand-computed timing, count and RAM-content expectations.
module tb_oam_dma;

   localparam int unsigned AW   = 8;
   localparam int unsigned DW   = 8;
   localparam int unsigned SAW  = 16;
   localparam int unsigned LEN  = 160;
   localparam int unsigned PACE = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [SAW-1:0] src_base;
   logic           busy, done;
   logic           gnt;
   logic           src_ce;
   logic [SAW-1:0] src_addr;
   logic [DW-1:0]  src_din = '0;
   logic           dst_ce, dst_we;
   logic [AW-1:0]  dst_addr;
   logic [DW-1:0]  dst_din;

   oam_dma #(.aw(AW), .dw(DW), .saw(SAW), .LEN(LEN), .PACE(PACE)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .src_base_i(src_base),
      .busy_o(busy), .done_o(done), .src_gnt_i(gnt), .src_ce_o(src_ce),
      .src_addr_o(src_addr), .src_din_i(src_din), .dst_ce_o(dst_ce),
      .dst_we_o(dst_we), .dst_addr_o(dst_addr), .dst_din_o(dst_din)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] srcfn(input logic [15:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // Source bus and destination RAM environment
   logic [7:0]  ram [256];
   int unsigned ram_stamp [256];
   always @(posedge clk) begin
      if (src_ce) src_din <= srcfn(src_addr);
      if (dst_ce && dst_we) begin
         ram[dst_addr]       <= dst_din;
         ram_stamp[dst_addr] <= cyc;
      end
   end

   // Transfer model: which index is read when, and what is written the cycle after
   logic        m_valid = 1'b0;
   logic        m_act = 1'b0, m_drain = 1'b0, m_pv = 1'b0;
   int unsigned m_n = 0, m_base = 0, m_paddr = 0, m_phase = 0;
   logic [7:0]  m_pdata = '0;
   logic        exp_rd, slot_open;
   int unsigned done_count = 0, done_cyc = 0;
   int unsigned wr_log [$];

   always @(negedge clk) begin
`ifdef OAM_DMA_PACE_EN
      slot_open = (m_phase == PACE - 1);
`else
      slot_open = 1'b1;
`endif
      exp_rd = m_act && gnt && slot_open;
      if (m_valid) begin
         chk("busy", 32'(busy), 32'(m_act || m_drain));
         chk("done", 32'(done), 32'(m_drain && !start));
         chk("src_ce", 32'(src_ce), 32'(exp_rd));
         if (exp_rd) chk("src_addr", 32'(src_addr), (m_base + m_n) & 32'hFFFF);
         chk("dst_ce", 32'(dst_ce), 32'(m_pv));
         chk("dst_we", 32'(dst_we), 32'(m_pv));
         if (m_pv) chk("dst_addr", 32'(dst_addr), m_paddr);
         chk("dst_din", 32'(dst_din), m_pv ? 32'(m_pdata) : 32'd0);
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (dst_we) wr_log.push_back(cyc);
      end
      if (rst) begin
         m_act = 1'b0; m_drain = 1'b0; m_pv = 1'b0;
         m_n = 0; m_base = 0; m_phase = 0;
         m_valid = 1'b1;
      end else begin
         m_pv = exp_rd;
         if (exp_rd) begin
            m_paddr = m_n % 256;
            m_pdata = srcfn(16'(m_base + m_n));
            m_n++;
         end
         m_drain = exp_rd && (m_n == LEN);
         if (m_drain) m_act = 1'b0;
         m_phase = (m_phase + 1) % PACE;
         if (start) begin
            m_act = 1'b1; m_drain = 1'b0;
            m_n = 0; m_base = 32'(src_base); m_phase = 0;
         end
      end
   end

   logic gmode = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (gmode) gnt = ~gnt;
   endtask

   task automatic start_xfer(input logic [15:0] b, output int unsigned t);
      start = 1'b1;
      src_base = b;
      t = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_to(input int unsigned target);
      for (int k = 0; k < 2000 && cyc < target; k++) step();
      chk("reach_cyc", cyc, target);
   endtask

   task automatic wait_done(input int limit);
      int unsigned d0;
      d0 = done_count;
      for (int k = 0; k < limit && done_count == d0; k++) step();
      chk("done_seen", 32'(done_count != d0), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, t1, n0, d0;
      rst = 1'b1; start = 1'b0; gnt = 1'b1; src_base = '0;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_src_ce", 32'(src_ce), 32'd0);
      chk("rst_dst_ce", 32'(dst_ce), 32'd0);
      chk("rst_dst_we", 32'(dst_we), 32'd0);
      chk("rst_src_addr", 32'(src_addr), 32'd0);
      chk("rst_dst_addr", 32'(dst_addr), 32'd0);
      chk("rst_dst_din", 32'(dst_din), 32'd0);

`ifdef OAM_DMA_PACE_EN
      // Paced transfer: one write every PACE clocks
      n0 = 32'(wr_log.size());
      start_xfer(16'hC000, t0);
      wait_done(900);
      chk("t6_done_cyc", done_cyc - t0, 32'd641);
      chk("t6_wr_count", 32'(wr_log.size()) - n0, 32'd160);
      if (wr_log.size() > n0) chk("t6_first_wr", wr_log[n0] - t0, 32'd5);
      for (int i = 1; i < 160; i++)
         if (wr_log.size() > n0 + i) chk("t6_gap", wr_log[n0+i] - wr_log[n0+i-1], 32'd4);
      for (int i = 0; i < 160; i++) chk("t6_ram", 32'(ram[i]), 32'(i[7:0] ^ 8'h5A));
`else
      // 1: continuous grant
      n0 = 32'(wr_log.size());
      start_xfer(16'hC000, t0);
      wait_done(400);
      chk("t1_done_cyc", done_cyc - t0, 32'd161);
      chk("t1_wr_count", 32'(wr_log.size()) - n0, 32'd160);
      if (wr_log.size() > n0) chk("t1_first_wr", wr_log[n0] - t0, 32'd2);
      chk("t1_busy_low", 32'(busy), 32'd0);
      for (int i = 0; i < 160; i++) chk("t1_ram", 32'(ram[i]), 32'(i[7:0] ^ 8'h5A));
      chk("t1_ram0", 32'(ram[0]), 32'h5A);
      chk("t1_ram159", 32'(ram[159]), 32'hC5);

      // 2: grant toggling every cycle
      gmode = 1'b1;
      n0 = 32'(wr_log.size());
      start_xfer(16'hC080, t0);
      wait_done(800);
      chk("t2_done_cyc", 32'((done_cyc - t0 == 320) || (done_cyc - t0 == 321)), 32'd1);
      chk("t2_wr_count", 32'(wr_log.size()) - n0, 32'd160);
      for (int i = 0; i < 160; i++) chk("t2_ram", 32'(ram[i]), 32'(8'(i + 8'h80) ^ 8'h5A));
      gmode = 1'b0;
      gnt = 1'b1;

      // 3: source address wraps FFFF -> 0000
      start_xfer(16'hFFF0, t0);
      wait_done(400);
      for (int i = 0; i < 160; i++) chk("t3_ram", 32'(ram[i]), 32'(8'(i + 8'hF0) ^ 8'h5A));
      chk("t3_ram0", 32'(ram[0]), 32'hAA);
      chk("t3_ram16", 32'(ram[16]), 32'h5A);
      chk("t3_ram159", 32'(ram[159]), 32'hD5);

      // 4: restart during write of index 49
      n0 = 32'(wr_log.size());
      d0 = done_count;
      start_xfer(16'hC000, t0);
      wait_to(t0 + 51);
      start_xfer(16'h1234, t1);
      wait_done(400);
      chk("t4_done_count", done_count - d0, 32'd1);
      chk("t4_done_cyc", done_cyc - t1, 32'd161);
      chk("t4_wr_count", 32'(wr_log.size()) - n0, 32'd211);
      if (wr_log.size() > n0 + 50) chk("t4_inflight_cyc", wr_log[n0+50] - t0, 32'd52);
      for (int i = 0; i < 160; i++) chk("t4_ram", 32'(ram[i]), 32'(8'(i + 8'h34) ^ 8'h5A));
      chk("t4_ram0", 32'(ram[0]), 32'h6E);

      // 5: reset during write of index 79
      n0 = 32'(wr_log.size());
      d0 = done_count;
      start_xfer(16'hC000, t0);
      wait_to(t0 + 81);
      rst = 1'b1;
      step();
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_dst_we", 32'(dst_we), 32'd0);
      rst = 1'b0;
      repeat (4) step();
      chk("t5_wr_count", 32'(wr_log.size()) - n0, 32'd80);
      chk("t5_no_done", done_count - d0, 32'd0);
      chk("t5_ram79", 32'(ram[79]), 32'h15);
      for (int i = 80; i < 160; i++) chk("t5_untouched", 32'(ram_stamp[i] < t0), 32'd1);

      // 7: start coincides with the final write
      d0 = done_count;
      n0 = 32'(wr_log.size());
      start_xfer(16'hC000, t0);
      wait_to(t0 + 161);
      start_xfer(16'hC000, t1);
      wait_done(400);
      chk("t7_done_count", done_count - d0, 32'd1);
      chk("t7_done_cyc", done_cyc - t1, 32'd161);
      chk("t7_wr_count", 32'(wr_log.size()) - n0, 32'd320);
`endif

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
